// File: rtl/hbridge_scan_monitor.sv
// hbridge_scan_monitor: read-side checker for the actuator cell scan.
// Registers the row/column H-bridge buses, decodes each drive run back into
// a cell index and level, rebuilds cells_state once per frame and collects
// frame-local fault flags.
//
//   state      | meaning
//   RUN_IDLE   | no drive run in progress (last stage-1 cycle was not active)
//   RUN_ACTIVE | a drive run is open; width is counting, glitches are checked
module hbridge_scan_monitor #(
  parameter int WIDTH_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [9:0]         rows_hbrige,
  input  logic [3:0]         cols_hbrige,
  input  logic               cell_invert,
  input  logic               frame_strobe,
  output logic               frame_valid,
  output logic [9:0]         cells_state_out,
  output logic [9:0]         cells_seen,
  output logic [3:0]         event_count,
  output logic [WIDTH_W-1:0] min_width,
  output logic               err_shoot,
  output logic               err_multi,
  output logic               err_polarity,
  output logic               err_glitch,
  output logic               err_repeat
);

  localparam logic [1:0]         CODE_IDLE    = 2'b10;
  localparam logic [1:0]         CODE_HIGH    = 2'b11;
  localparam logic [1:0]         CODE_ILLEGAL = 2'b01;
  localparam logic [WIDTH_W-1:0] WIDTH_MAX    = '1;

  typedef enum logic {RUN_IDLE, RUN_ACTIVE} run_state_e;

  // flag vector order: [4] shoot, [3] multi, [2] polarity, [1] glitch, [0] repeat
  logic [9:0]         rows_q;
  logic [3:0]         cols_q;
  logic               strobe_q;
  run_state_e         run_q, run_d;
  logic [3:0]         p_q, p_d;
  logic               lvl_q, lvl_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic [9:0]         shadow_q, shadow_d;
  logic [9:0]         seen_q, seen_d;
  logic [3:0]         count_q, count_d;
  logic [WIDTH_W-1:0] minw_q, minw_d;
  logic [4:0]         flags_q, flags_d;
  logic               valid_q;
  logic [9:0]         state_out_q, seen_out_q;
  logic [3:0]         count_out_q;
  logic [WIDTH_W-1:0] minw_out_q;
  logic [4:0]         flags_out_q;

  logic [2:0] n_row;
  logic [1:0] n_col;
  logic [2:0] r_idx;
  logic       c_idx;
  logic [1:0] row_code, col_code;
  logic       shoot, active, multi, polarity, glitch;
  logic       lvl_cur, col_lvl;
  logic [3:0] p_cur, bit_idx;
  logic       run_start, run_stop;

  // Physical index to cells_state bit position.
  function automatic logic [3:0] remap(input logic [3:0] p);
    case (p)
      4'd3:    remap = 4'd6;
      4'd4:    remap = 4'd8;
      4'd5:    remap = 4'd3;
      4'd6:    remap = 4'd4;
      4'd7:    remap = 4'd5;
      4'd8:    remap = 4'd7;
      default: remap = p;
    endcase
  endfunction

  // Stage 1: register the buses and strobe; reset loads idle codes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rows_q   <= {5{CODE_IDLE}};
      cols_q   <= {2{CODE_IDLE}};
      strobe_q <= 1'b0;
    end else begin
      rows_q   <= rows_hbrige;
      cols_q   <= cols_hbrige;
      strobe_q <= frame_strobe;
    end
  end

  // Decode the stage-1 bus pattern into activity, cell index, level and faults.
  always_comb begin
    n_row    = '0;
    n_col    = '0;
    r_idx    = '0;
    c_idx    = 1'b0;
    row_code = CODE_IDLE;
    col_code = CODE_IDLE;
    shoot    = 1'b0;
    for (int r = 0; r < 5; r++) begin
      if (rows_q[2*r +: 2] == CODE_ILLEGAL) shoot = 1'b1;
      if (rows_q[2*r +: 2] != CODE_IDLE) begin
        n_row    = n_row + 3'd1;
        r_idx    = 3'(r);
        row_code = rows_q[2*r +: 2];
      end
    end
    for (int c = 0; c < 2; c++) begin
      if (cols_q[2*c +: 2] == CODE_ILLEGAL) shoot = 1'b1;
      if (cols_q[2*c +: 2] != CODE_IDLE) begin
        n_col    = n_col + 2'd1;
        c_idx    = 1'(c);
        col_code = cols_q[2*c +: 2];
      end
    end
    active   = (n_row == 3'd1) && (n_col == 2'd1);
    multi    = ((n_row != 3'd0) || (n_col != 2'd0)) && !active;
    p_cur    = (c_idx ? 4'd5 : 4'd0) + {1'b0, r_idx};
    bit_idx  = remap(p_cur);
    lvl_cur  = (row_code == CODE_HIGH) ^ cell_invert;
    col_lvl  = (col_code == CODE_HIGH) ^ cell_invert;
    polarity = active && (lvl_cur == col_lvl);
    glitch   = (run_q == RUN_ACTIVE) && active && ((p_cur != p_q) || (lvl_cur != lvl_q));
  end

  // Run state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) run_q <= RUN_IDLE;
    else       run_q <= run_d;
  end

  // Run next-state: start on idle->active, stop on active->idle.
  always_comb begin
    run_d     = run_q;
    run_start = 1'b0;
    run_stop  = 1'b0;
    case (run_q)
      RUN_IDLE: if (active) begin
        run_d     = RUN_ACTIVE;
        run_start = 1'b1;
      end
      RUN_ACTIVE: if (!active) begin
        run_d    = RUN_IDLE;
        run_stop = 1'b1;
      end
      default: run_d = RUN_IDLE;
    endcase
  end

  // Accumulator next-state, including this cycle's events so that a frame
  // closing on the same cycle still sees them.
  always_comb begin
    p_d      = p_q;
    lvl_d    = lvl_q;
    width_d  = width_q;
    shadow_d = shadow_q;
    seen_d   = seen_q;
    count_d  = count_q;
    minw_d   = minw_q;
    flags_d  = flags_q | {shoot, multi, polarity, glitch, 1'b0};
    if (run_start) begin
      p_d               = p_cur;
      lvl_d             = lvl_cur;
      width_d           = {{(WIDTH_W-1){1'b0}}, 1'b1};
      shadow_d[bit_idx] = lvl_cur;
      seen_d[bit_idx]   = 1'b1;
      if (seen_q[bit_idx]) flags_d[0] = 1'b1;
      if (count_q != 4'hF) count_d = count_q + 4'd1;
    end else if (active && (width_q != WIDTH_MAX)) begin
      width_d = width_q + 1'b1;
    end
    if (run_stop && (width_q < minw_q)) minw_d = width_q;
  end

  // Run tracking registers; an open run carries across frame close.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_q     <= '0;
      lvl_q   <= 1'b0;
      width_q <= '0;
    end else begin
      p_q     <= p_d;
      lvl_q   <= lvl_d;
      width_q <= width_d;
    end
  end

  // Frame accumulators and published results; strobe publishes and clears.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_q    <= '0;
      seen_q      <= '0;
      count_q     <= '0;
      minw_q      <= WIDTH_MAX;
      flags_q     <= '0;
      valid_q     <= 1'b0;
      state_out_q <= '0;
      seen_out_q  <= '0;
      count_out_q <= '0;
      minw_out_q  <= WIDTH_MAX;
      flags_out_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      valid_q  <= strobe_q;
      if (strobe_q) begin
        state_out_q <= shadow_d;
        seen_out_q  <= seen_d;
        count_out_q <= count_d;
        minw_out_q  <= minw_d;
        flags_out_q <= flags_d;
        seen_q      <= '0;
        count_q     <= '0;
        minw_q      <= WIDTH_MAX;
        flags_q     <= '0;
      end else begin
        seen_q  <= seen_d;
        count_q <= count_d;
        minw_q  <= minw_d;
        flags_q <= flags_d;
      end
    end
  end

  assign frame_valid     = valid_q;
  assign cells_state_out = state_out_q;
  assign cells_seen      = seen_out_q;
  assign event_count     = count_out_q;
  assign min_width       = minw_out_q;
  assign err_shoot       = flags_out_q[4];
  assign err_multi       = flags_out_q[3];
  assign err_polarity    = flags_out_q[2];
  assign err_glitch      = flags_out_q[1];
  assign err_repeat      = flags_out_q[0];

endmodule

// File: doc/hbridge_scan_monitor.md
Name: hbridge_scan_monitor

Overview:
- Read-side checker for the actuator cell scan.
- Samples the 10-bit row H-bridge bus and 4-bit column H-bridge bus produced by the cell scan controller.
- Decodes each drive pulse back into a cell index and cell state, then rebuilds the 10-bit cells_state word once per scan frame.
- Flags illegal bridge codes, decoding ambiguities and timing faults; feeds loopback self-test and debug status registers.

Parameters:
- WIDTH_W, 16, width of the saturating pulse-width measurement counter.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rows_hbrige  input  10  row bridge codes, pair r = bits [2r+1:2r]
- cols_hbrige  input  4  column bridge codes, pair c = bits [2c+1:2c]
- cell_invert  input  1  polarity inversion setting used by the driver
- frame_strobe  input  1  end-of-scan pulse (driver update_done)
- frame_valid  output  1  one-cycle pulse: frame results updated
- cells_state_out  output  10  reconstructed cells_state word
- cells_seen  output  10  cells driven during the frame, cells_state bit order
- event_count  output  4  drive events in the frame, saturates at 15
- min_width  output  WIDTH_W  shortest completed drive run in the frame, saturating
- err_shoot  output  1  a 2'b01 bridge code was observed
- err_multi  output  1  bad active combination (>1 row, >1 col, or row without col / col without row)
- err_polarity  output  1  active row and column driven to the same level
- err_glitch  output  1  cell index or level changed inside one run
- err_repeat  output  1  same cell started more than once in the frame

Behaviour:
- Bridge pair codes:
  - 2'b10 = idle
  - 2'b11 = drive high
  - 2'b00 = drive low
  - 2'b01 = illegal
- Stage 1: rows_hbrige, cols_hbrige and frame_strobe are registered. All decoding uses the stage-1 values.
- Active cycle: exactly one row pair and exactly one column pair are non-idle.
- Cell decode:
  - Physical index p = c*5 + r.
  - Level = (row pair == 2'b11) XOR cell_invert.
  - Legal only when row level != column level; otherwise err_polarity is set (sticky for the frame).
- Remap from physical index to cells_state bit:
  - p0->0, p1->1, p2->2, p5->3, p6->4, p7->5, p3->6, p8->7, p4->8, p9->9.
- Run tracking:
  - Run starts on an idle->active transition.
  - At run start:
    - Write the decoded level into the shadow state.
    - Set the seen bit.
    - Increment event_count (saturating).
    - If the seen bit was already set, set err_repeat.
  - While a run is active, any change of p or level sets err_glitch.
  - Width counter counts active cycles, saturating at all-ones.
  - At run end (active->idle), min_width_acc = min(min_width_acc, width).
  - A run still open at frame close is credited to the next frame.
- Error accumulation:
  - Any 2'b01 code sets err_shoot.
  - A non-idle, non-active pattern sets err_multi.
  - Errors accumulate in frame-local flags.
- Frame close: when stage-1 frame_strobe = 1, on the next edge:
  - Copy the shadow state, seen mask, counters and flags to the outputs.
  - Pulse frame_valid high for exactly one cycle.
  - Clear accumulators: seen=0, count=0, min=all-ones, flags=0.
  - Keep the shadow state: unseen cells (skipped by partial update) retain their previous frame value.
- Total latency: strobe at input edge k -> frame_valid high in the cycle after edge k+2.
- Simultaneous events: a run start processed in the same stage-1 cycle as the strobe belongs to the closing frame. Back-to-back strobes yield two frames; the second has event_count=0 and min_width=all-ones.
- Reset (async, any time):
  - All outputs = 0, except min_width = all-ones.
  - Shadow state = 0; accumulators cleared.
  - Stage-1 registers load idle codes (2'b10) and strobe = 0.

Test Plan:
- Normal scan: cell_invert=0, cells 0..9 driven in order with cells_state=10'h2A5, each run 4 cycles, then strobe -> frame_valid one cycle after +2 latency; cells_state_out=10'h2A5, cells_seen=10'h3FF, event_count=10, min_width=4, no errors.
- Inverted polarity: same sequence with cell_invert=1 and the driver's inverted levels -> cells_state_out=10'h2A5, err_polarity=0.
- Partial update: frame 1 all cells = 10'h3FF; frame 2 drives only physical cell 3 with level 0 -> cells_seen=10'h040, cells_state_out=10'h3BF.
- Faults:
  - row0 pair = 2'b01 -> err_shoot=1.
  - rows 0 and 1 both active -> err_multi=1.
  - row high with column high -> err_polarity=1.
  - Run switches from p=2 to p=7 mid-run -> err_glitch=1.
  - Each flag clears after the next clean frame.
- Reset mid-run: assert reset during an active run of cell 4 -> outputs zero and min_width=all-ones immediately; next frame reports only post-reset events.
